// File: rtl/grid_cell_to_pixel.sv
// grid_cell_to_pixel: row-major board-cell index -> sprite pixel anchor (x,y).
// Sequential row/col decode with no multiplier or divider, then a registered move.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   cell_in           target cell index (row*COLS+col)
//   cell_valid        request strobe; taken when cell_valid & cell_ready
//   cell_ready        high only while idle
//   frame_tick        one pulse per video frame (drives the slide animation)
//   pix_x, pix_y      current sprite anchor; 0 until the first placement
//   pix_en            sprite has been placed at least once since reset
//   busy              decoding or moving
//   done              one-cycle pulse when the sprite reaches its target
//   err               one-cycle pulse when an out-of-range cell is requested
//
// Optional feature: define GRID_CELL_ANIM_EN to slide the sprite STEP pixels
// per axis per frame_tick instead of jumping straight to the target.
module grid_cell_to_pixel #(
    parameter int COLS     = 3,
    parameter int ROWS     = 3,
    parameter int ORIGIN_X = 200,
    parameter int ORIGIN_Y = 75,
    parameter int PITCH_X  = 225,
    parameter int PITCH_Y  = 160,
    parameter int POS_W    = 4,
    parameter int PIX_W    = 10,
    parameter int STEP     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] cell_in,
    input  logic             cell_valid,
    output logic             cell_ready,
    input  logic             frame_tick,
    output logic [PIX_W-1:0] pix_x,
    output logic [PIX_W-1:0] pix_y,
    output logic             pix_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        MOVE
    } state_t;

    // One extra bit so ROWS*COLS == 2**POS_W still compares correctly.
    localparam logic [POS_W:0]   N_CELLS = (POS_W+1)'(ROWS * COLS);
    localparam logic [POS_W-1:0] COLS_P  = POS_W'(COLS);
    localparam logic [PIX_W-1:0] OX      = PIX_W'(ORIGIN_X);
    localparam logic [PIX_W-1:0] OY      = PIX_W'(ORIGIN_Y);
    localparam logic [PIX_W-1:0] PX      = PIX_W'(PITCH_X);
    localparam logic [PIX_W-1:0] PY      = PIX_W'(PITCH_Y);

    state_t           state_q, state_d;
    logic [POS_W-1:0] rem_q, rem_d;
    logic [PIX_W-1:0] tx_q, tx_d;
    logic [PIX_W-1:0] ty_q, ty_d;
    logic [PIX_W-1:0] px_q, px_d;
    logic [PIX_W-1:0] py_q, py_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             at_tgt;

`ifdef GRID_CELL_ANIM_EN
    localparam logic [PIX_W-1:0] STEP_P = PIX_W'(STEP);

    // Move one axis toward its target by at most STEP_P, never overshooting.
    function automatic logic [PIX_W-1:0] step_to(
        input logic [PIX_W-1:0] cur,
        input logic [PIX_W-1:0] tgt
    );
        logic [PIX_W-1:0] d;
        if (tgt > cur) begin
            d = tgt - cur;
            return cur + ((d > STEP_P) ? STEP_P : d);
        end else begin
            d = cur - tgt;
            return cur - ((d > STEP_P) ? STEP_P : d);
        end
    endfunction
`else
    // frame_tick and STEP only matter for the slide animation.
    logic unused_anim;
    assign unused_anim = frame_tick ^ (STEP == 0);
`endif

    assign at_tgt = en_q && (px_q == tx_q) && (py_q == ty_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            px_q    <= px_d;
            py_q    <= py_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        px_d    = px_q;
        py_d    = py_q;
        en_d    = en_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cell_valid) begin
                    if ({1'b0, cell_in} >= N_CELLS) begin
                        err_d = 1'b1;
                    end else begin
                        rem_d   = cell_in;
                        tx_d    = OX;
                        ty_d    = OY;
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                // Rows first by repeated subtraction, then columns.
                if (rem_q >= COLS_P) begin
                    rem_d = rem_q - COLS_P;
                    ty_d  = ty_q + PY;
                end else if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                    tx_d  = tx_q + PX;
                end else begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (at_tgt) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!en_q) begin
                    // First placement always jumps.
                    px_d = tx_q;
                    py_d = ty_q;
                    en_d = 1'b1;
`ifdef GRID_CELL_ANIM_EN
                end else if (frame_tick) begin
                    px_d = step_to(px_q, tx_q);
                    py_d = step_to(py_q, ty_q);
                end
`else
                end else begin
                    px_d = tx_q;
                    py_d = ty_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign cell_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign pix_x      = px_q;
    assign pix_y      = py_q;
    assign pix_en     = en_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
